// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding and
// the address bit that picks a 32-bit word out of the 64-bit SRAM return.
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   localparam int unsigned WORD_SEL_BIT = 2;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned MEM_DATA_W   = 64;

   // Address bit set selects the low word; clear selects the high word.
   function automatic logic [DATA_W-1:0] select_word(input logic [MEM_DATA_W-1:0] dword,
                                                     input logic                  sel);
      return sel ? dword[DATA_W-1:0] : dword[MEM_DATA_W-1:DATA_W];
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_grant.sv
// Combinational grant decision between the instruction and data ports,
// round-robin against the last-served port or data-always-wins.
module rr_grant #(
   parameter int FIXED_PRI = 0
) (
   input  logic i_req,
   input  logic d_req,
   input  logic last_d,
   output logic grant_valid,
   output logic grant_d
);

   always_comb begin
      grant_valid = i_req | d_req;
      grant_d     = d_req;
      // Only a conflict needs a policy; a lone request always wins.
      if (i_req && d_req) begin
         grant_d = (FIXED_PRI != 0) ? 1'b1 : ~last_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single SRAM controller
// port. Valid/ready: a request is a level held in IDLE; completion is a
// one-cycle ready pulse to the owner; mem_ready is honoured only in ACCESS.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int FIXED_PRI = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic [DATA_W-1:0]     i_rdata,
   output logic                  i_ready,
   input  logic                  d_r_en,
   input  logic                  d_w_en,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  d_ready,
   output logic                  mem_r_en,
   output logic                  mem_w_en,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [MEM_DATA_W-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output arb_state_t            dbg_state
);

   arb_state_t          state_q;
   arb_state_t          state_d;
   logic                owner_d_q;
   logic                write_q;
   logic                last_d_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                grant_valid;
   logic                grant_d;
   logic                latch_en;
   logic                capture_en;

   rr_grant #(
      .FIXED_PRI(FIXED_PRI)
   ) u_rr_grant (
      .i_req      (i_req),
      .d_req      (d_r_en | d_w_en),
      .last_d     (last_d_q),
      .grant_valid(grant_valid),
      .grant_d    (grant_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      latch_en   = 1'b0;
      capture_en = 1'b0;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      i_ready    = 1'b0;
      d_ready    = 1'b0;
      busy       = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (grant_valid) begin
               latch_en = 1'b1;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            mem_r_en = ~write_q;
            mem_w_en = write_q;
            if (mem_ready) begin
               capture_en = ~write_q;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            i_ready = ~owner_d_q;
            d_ready = owner_d_q;
            state_d = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Everything about the access is frozen at grant so requester inputs
   // cannot disturb it until the next IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_d_q <= 1'b0;
         write_q   <= 1'b0;
         last_d_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         if (latch_en) begin
            owner_d_q <= grant_d;
            write_q   <= grant_d & d_w_en;
            addr_q    <= grant_d ? d_addr : i_addr;
            wdata_q   <= grant_d ? d_wdata : '0;
         end
         if (capture_en) begin
            rdata_q <= select_word(mem_rdata, addr_q[WORD_SEL_BIT]);
         end
         if (state_q == ST_DONE) begin
            last_d_q <= owner_d_q;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = rdata_q;
   assign d_rdata   = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one round-robin and one fixed-priority instance
// share stimulus and are checked every cycle against a transaction-level model.
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_r_en = 1'b0;
   logic        d_w_en = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [63:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   logic [31:0] i_rdata_w [2];
   logic        i_ready_w [2];
   logic [31:0] d_rdata_w [2];
   logic        d_ready_w [2];
   logic        mem_r_en_w [2];
   logic        mem_w_en_w [2];
   logic [31:0] mem_addr_w [2];
   logic [31:0] mem_wdata_w [2];
   logic        busy_w [2];
   arb_state_t  dbg_w [2];

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(32), .FIXED_PRI(0)) dut_rr (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr),
      .i_rdata(i_rdata_w[0]), .i_ready(i_ready_w[0]),
      .d_r_en(d_r_en), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_w[0]), .d_ready(d_ready_w[0]),
      .mem_r_en(mem_r_en_w[0]), .mem_w_en(mem_w_en_w[0]),
      .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy_w[0]), .dbg_state(dbg_w[0])
   );

   sram_port_arbiter #(.ADDR_W(32), .FIXED_PRI(1)) dut_fp (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr),
      .i_rdata(i_rdata_w[1]), .i_ready(i_ready_w[1]),
      .d_r_en(d_r_en), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_w[1]), .d_ready(d_ready_w[1]),
      .mem_r_en(mem_r_en_w[1]), .mem_w_en(mem_w_en_w[1]),
      .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy_w[1]), .dbg_state(dbg_w[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_in_flight [2];
   bit          m_resp_due  [2];
   bit          m_own_d     [2];
   bit          m_write     [2];
   bit          m_last_d    [2];
   logic [31:0] m_addr      [2];
   logic [31:0] m_wdata     [2];
   logic [31:0] m_rdata     [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            m_in_flight[k] = 0; m_resp_due[k] = 0; m_own_d[k] = 0; m_write[k] = 0;
            m_last_d[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
            chk($sformatf("rst_busy[%0d]", k), busy_w[k], 0);
            chk($sformatf("rst_strobes[%0d]", k), {mem_r_en_w[k], mem_w_en_w[k]}, 0);
            chk($sformatf("rst_ready[%0d]", k), {i_ready_w[k], d_ready_w[k]}, 0);
            chk($sformatf("rst_addr[%0d]", k), mem_addr_w[k], 0);
         end else begin
            chk($sformatf("busy[%0d]", k), busy_w[k], m_in_flight[k] | m_resp_due[k]);
            chk($sformatf("mem_r_en[%0d]", k), mem_r_en_w[k], m_in_flight[k] & ~m_write[k]);
            chk($sformatf("mem_w_en[%0d]", k), mem_w_en_w[k], m_in_flight[k] & m_write[k]);
            chk($sformatf("i_ready[%0d]", k), i_ready_w[k], m_resp_due[k] & ~m_own_d[k]);
            chk($sformatf("d_ready[%0d]", k), d_ready_w[k], m_resp_due[k] & m_own_d[k]);
            chk($sformatf("ready_excl[%0d]", k), i_ready_w[k] & d_ready_w[k], 0);
            if (m_in_flight[k]) chk($sformatf("mem_addr[%0d]", k), mem_addr_w[k], m_addr[k]);
            if (m_in_flight[k] && m_write[k])
               chk($sformatf("mem_wdata[%0d]", k), mem_wdata_w[k], m_wdata[k]);
            if (m_resp_due[k] && !m_write[k]) begin
               if (m_own_d[k]) chk($sformatf("d_rdata[%0d]", k), d_rdata_w[k], m_rdata[k]);
               else            chk($sformatf("i_rdata[%0d]", k), i_rdata_w[k], m_rdata[k]);
            end
            // advance the model to what the coming edge must produce
            if (m_in_flight[k]) begin
               if (mem_ready) begin
                  if (!m_write[k])
                     m_rdata[k] = m_addr[k][2] ? mem_rdata[31:0] : mem_rdata[63:32];
                  m_in_flight[k] = 0;
                  m_resp_due[k]  = 1;
               end
            end else if (m_resp_due[k]) begin
               m_resp_due[k] = 0;
               m_last_d[k]   = m_own_d[k];
            end else if (i_req || d_r_en || d_w_en) begin
               bit dr;
               bit gd;
               dr = d_r_en | d_w_en;
               if (i_req && dr) gd = (k == 1) ? 1'b1 : ~m_last_d[k];
               else             gd = dr;
               m_own_d[k]     = gd;
               m_write[k]     = gd & d_w_en;
               m_addr[k]      = gd ? d_addr : i_addr;
               m_wdata[k]     = d_wdata;
               m_in_flight[k] = 1;
            end
         end
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [0:0] exp_q [$];
   logic [0:0] obs_q [$];

   initial begin
      int d_cnt_fp;
      int i_cnt_fp;
      logic [31:0] r;

      #2;
      for (int k = 0; k < 2; k++) begin
         chk("init_busy", busy_w[k], 0);
         chk("init_rdata", i_rdata_w[k], 0);
         chk("init_wdata", mem_wdata_w[k], 0);
      end
      tick();
      tick();
      rst = 1'b1;

      // lone instruction read, mem_ready two cycles after the request
      tick();
      i_req = 1'b1; i_addr = 32'h400;
      tick();
      i_req = 1'b0;
      chk("r039_mem_r_en", mem_r_en_w[0], 1);
      chk("r039_mem_addr", mem_addr_w[0], 32'h400);
      tick();
      mem_ready = 1'b1; mem_rdata = 64'h11112222_33334444;
      chk("r039_no_early_ready", i_ready_w[0], 0);
      tick();
      mem_ready = 1'b0;
      chk("r039_i_ready", i_ready_w[0], 1);
      chk("r039_i_rdata", i_rdata_w[0], 32'h11112222);
      chk("r039_d_ready", d_ready_w[0], 0);
      tick();
      chk("r039_ready_drop", i_ready_w[0], 0);
      chk("r039_idle", busy_w[0], 0);

      // both ports requesting continuously after an instruction grant
      i_req = 1'b1; d_r_en = 1'b1; i_addr = 32'h408; d_addr = 32'h40C;
      mem_ready = 1'b1; mem_rdata = 64'hAAAA5555_CCCC3333;
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
      d_cnt_fp = 0; i_cnt_fp = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (i_ready_w[0]) obs_q.push_back(1'b0);
         if (d_ready_w[0]) obs_q.push_back(1'b1);
         if (d_ready_w[1]) d_cnt_fp++;
         if (i_ready_w[1]) i_cnt_fp++;
      end
      chk("r040_ready_count", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0)
         chk("r040_order", obs_q.pop_front(), exp_q.pop_front());
      chk("r042_fp_d_grants", d_cnt_fp, 4);
      chk("r042_fp_i_grants", i_cnt_fp, 0);
      i_req = 1'b0; d_r_en = 1'b0;
      repeat (4) tick();
      mem_ready = 1'b0;
      chk("drain_idle", busy_w[0] | busy_w[1], 0);

      // data write held until mem_ready, inputs changing mid-access
      d_w_en = 1'b1; d_addr = 32'h404; d_wdata = 32'hDEADBEEF;
      tick();
      d_w_en = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; i_req = 1'b1; i_addr = 32'h123;
      for (int c = 0; c < 3; c++) begin
         chk("r041_w_en", mem_w_en_w[0], 1);
         chk("r041_r_en", mem_r_en_w[0], 0);
         chk("r041_addr", mem_addr_w[0], 32'h404);
         chk("r041_wdata", mem_wdata_w[0], 32'hDEADBEEF);
         if (c == 2) mem_ready = 1'b1;
         tick();
      end
      i_req = 1'b0; mem_ready = 1'b0;
      chk("r041_d_ready", d_ready_w[0], 1);
      chk("r041_i_ready", i_ready_w[0], 0);
      chk("r041_w_en_drop", mem_w_en_w[0], 0);
      tick();
      chk("r041_d_ready_once", d_ready_w[0], 0);
      repeat (3) tick();

      // reset in the middle of an access
      i_req = 1'b1; i_addr = 32'h500;
      tick();
      i_req = 1'b0;
      chk("r043_in_access", mem_r_en_w[0], 1);
      #2 rst = 1'b0; mem_ready = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("r043_async_busy", busy_w[k], 0);
         chk("r043_async_r_en", mem_r_en_w[k], 0);
         chk("r043_async_addr", mem_addr_w[k], 0);
         chk("r043_async_ready", {i_ready_w[k], d_ready_w[k]}, 0);
      end
      tick();
      rst = 1'b1; mem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("r043_post_busy", busy_w[0], 0);
         chk("r043_no_ready", i_ready_w[0] | d_ready_w[0], 0);
         tick();
      end

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         i_req  = ($urandom_range(0, 9) < 5);
         d_r_en = ($urandom_range(0, 9) < 4);
         d_w_en = ($urandom_range(0, 9) < 3);
         r = $urandom(); i_addr = r & 32'hFFFF_FFFC;
         r = $urandom(); d_addr = r & 32'hFFFF_FFFC;
         d_wdata   = $urandom();
         mem_ready = ($urandom_range(0, 9) < 4);
         mem_rdata = {$urandom(), $urandom()};
         rst       = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst = 1'b1; i_req = 1'b0; d_r_en = 1'b0; d_w_en = 1'b0; mem_ready = 1'b1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
